// File: rtl/mux4_to_1_pkg.sv
// Shared definitions for the 4-to-1 selector: select encodings, the select
// type and the default data width.
// Optional feature macro used by this block: MUX4_TO_1_PARITY_EN.
package mux4_to_1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  localparam int MUX4_TO_1_WIDTH_DEF = 1;

endpackage

// File: rtl/mux4_to_1_if.sv
// Bundle of the selector's data, select and result signals.
// The master side drives data and select; the slave side (the mux) returns
// the combinational and registered results.
// With MUX4_TO_1_PARITY_EN defined the bundle also carries out_par.
interface mux4_to_1_if
  import mux4_to_1_pkg::*;
#(
  parameter int WIDTH = MUX4_TO_1_WIDTH_DEF
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  sel_t             s;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
`ifdef MUX4_TO_1_PARITY_EN
  logic             out_par;

  modport master (output a, b, c, d, s, input out, out_q, out_par);
  modport slave  (input a, b, c, d, s, output out, out_q, out_par);
`else
  modport master (output a, b, c, d, s, input out, out_q);
  modport slave  (input a, b, c, d, s, output out, out_q);
`endif

endinterface

// File: rtl/mux4_to_1_core.sv
// Purely combinational WIDTH-bit 4-to-1 selector. No clock, no reset; only
// the currently selected input can influence the result.
module mux4_to_1_core
  import mux4_to_1_pkg::*;
#(
  parameter int WIDTH = MUX4_TO_1_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             s,
  output logic [WIDTH-1:0] y
);

  // Full-case decode of the select onto the four data inputs.
  always_comb begin
    y = a;
    case (s)
      SEL_A: y = a;
      SEL_B: y = b;
      SEL_C: y = c;
      SEL_D: y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mux4_to_1.sv
// 4-to-1 selector with a zero-latency combinational output and a registered
// copy for timing-critical consumers. The register clears asynchronously on
// rst and reloads on the first rising clk edge after rst falls.
// Optional feature macro: MUX4_TO_1_PARITY_EN adds out_par, the even parity
// of out_q, registered alongside it.
module mux4_to_1
  import mux4_to_1_pkg::*;
#(
  parameter int WIDTH = MUX4_TO_1_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  mux4_to_1_if.slave  bus
);

  logic [WIDTH-1:0] sel_data;

  mux4_to_1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a (bus.a),
    .b (bus.b),
    .c (bus.c),
    .d (bus.d),
    .s (bus.s),
    .y (sel_data)
  );

  assign bus.out = sel_data;

`ifdef MUX4_TO_1_PARITY_EN
  // Register the selected data and its parity together so both are valid in
  // the same cycle; parity of the value being loaded equals parity of out_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_q   <= '0;
      bus.out_par <= 1'b0;
    end else begin
      bus.out_q   <= sel_data;
      bus.out_par <= ^sel_data;
    end
  end
`else
  // Register the selected data every cycle; no enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_q <= '0;
    end else begin
      bus.out_q <= sel_data;
    end
  end
`endif

endmodule

// File: tb/tb_mux4_to_1.sv
// Self-checking bench for mux4_to_1. A WIDTH=8 instance is driven with
// directed and random vectors; expected registered results are queued by the
// driver and consumed by an independent monitor after every rising edge.
// A WIDTH=1 instance covers single-bit selection with X on unselected inputs.
// Honours MUX4_TO_1_PARITY_EN when defined.
module tb_mux4_to_1;
  import mux4_to_1_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];

  mux4_to_1_if #(.WIDTH(W)) bus8 ();
  mux4_to_1_if #(.WIDTH(1)) bus1 ();

  mux4_to_1 #(.WIDTH(W)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  mux4_to_1 #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // 100 MHz clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Reference: pick the input whose position in the list equals the select.
  function automatic logic [W-1:0] ref_select(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                              input logic [W-1:0] rc, input logic [W-1:0] rd,
                                              input logic [1:0] rs);
    logic [W-1:0] inputs [4];
    inputs[0] = ra;
    inputs[1] = rb;
    inputs[2] = rc;
    inputs[3] = rd;
    return inputs[rs];
  endfunction

  // Reference parity: odd number of ones gives 1.
  function automatic logic ref_parity(input logic [W-1:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one vector just after a falling edge, check the combinational
  // output at once, and queue the value out_q must show after the next edge.
  task automatic applyStimulus(input logic [W-1:0] na, input logic [W-1:0] nb,
                               input logic [W-1:0] nc, input logic [W-1:0] nd,
                               input logic [1:0] ns, input logic nrst);
    logic [W-1:0] sel;
    @(negedge clk);
    bus8.a = na;
    bus8.b = nb;
    bus8.c = nc;
    bus8.d = nd;
    bus8.s = ns;
    rst    = nrst;
    sel    = ref_select(na, nb, nc, nd, ns);
    #1;
    checkOutput("out", bus8.out, sel);
    exp_q.push_back(nrst ? '0 : sel);
  endtask

  // Monitor: after each rising edge, compare out_q (and parity) with the
  // oldest queued expectation.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("out_q", bus8.out_q, e);
`ifdef MUX4_TO_1_PARITY_EN
        checkOutput("out_par", {{(W-1){1'b0}}, bus8.out_par}, {{(W-1){1'b0}}, ref_parity(e)});
`endif
      end
    end
  end

  // Main sequence.
  initial begin
    logic [W-1:0] ra, rb, rc, rd;
    logic [1:0]   rs;
    logic         rr;

    rst    = 1'b1;
    bus8.a = '0;
    bus8.b = '0;
    bus8.c = '0;
    bus8.d = '0;
    bus8.s = SEL_A;
    bus1.a = 1'b0;
    bus1.b = 1'b0;
    bus1.c = 1'b0;
    bus1.d = 1'b0;
    bus1.s = SEL_A;
    #2;
    checkOutput("reset_out_q8", bus8.out_q, 8'h00);
    checkOutput("reset_out_q1", {7'b0, bus1.out_q}, 8'h00);

    // Single-bit stepping with X on every unselected input.
    for (int sv = 0; sv < 4; sv++) begin
      for (int v = 0; v < 2; v++) begin
        bus1.a = 1'bx;
        bus1.b = 1'bx;
        bus1.c = 1'bx;
        bus1.d = 1'bx;
        case (sv)
          0: bus1.a = v[0];
          1: bus1.b = v[0];
          2: bus1.c = v[0];
          default: bus1.d = v[0];
        endcase
        bus1.s = sv[1:0];
        #20;
        checkOutput("w1_out", {7'b0, bus1.out}, {7'b0, v[0]});
      end
    end

    // Held reset with clock running: out follows, out_q stays cleared.
    bus8.a = 8'hFF;
    bus8.s = SEL_A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("rst_hold_out_q", bus8.out_q, 8'h00);
      checkOutput("rst_hold_out", bus8.out, 8'hFF);
`ifdef MUX4_TO_1_PARITY_EN
      checkOutput("rst_hold_par", {7'b0, bus8.out_par}, 8'h00);
`endif
    end
    applyStimulus(8'hFF, 8'h00, 8'h00, 8'h00, SEL_A, 1'b0);

    // Select c with distinct data on every input.
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, SEL_C, 1'b0);

    // Load 8'h44, then assert reset between edges.
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44, SEL_D, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_out_q", bus8.out_q, 8'h00);
`ifdef MUX4_TO_1_PARITY_EN
    checkOutput("async_rst_par", {7'b0, bus8.out_par}, 8'h00);
`endif

    // Select and selected data change in the same timestep.
    applyStimulus(8'h5A, 8'h00, 8'h00, 8'h00, SEL_A, 1'b0);
    applyStimulus(8'h5A, 8'h00, 8'h00, 8'hA5, SEL_D, 1'b0);

    // Parity-oriented values (checked by the monitor when parity is built).
    applyStimulus(8'h07, 8'h00, 8'h00, 8'h00, SEL_A, 1'b0);
    applyStimulus(8'h03, 8'h00, 8'h00, 8'h00, SEL_A, 1'b0);

    // Random vectors with occasional reset cycles.
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = W'($urandom);
      rd = W'($urandom);
      rs = 2'($urandom_range(0, 3));
      rr = ($urandom_range(0, 15) == 0);
      applyStimulus(ra, rb, rc, rd, rs, rr);
    end

    // Let the monitor consume the last expectation, then confirm it did.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", W'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux4_to_1.md
Name: mux4_to_1

Overview:
- Parameterised 4-to-1 selector; data inputs a/b/c/d are routed to the output by a 2-bit select s.
- Provides a combinational output `out` with zero latency.
- Provides a registered copy `out_q` for timing-critical consumers.
- Used as a leaf datapath primitive in the low-level lab designs.

Parameters:
- WIDTH, 1, bit width of each data input and of both outputs (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  data input, selected when s=2'b00.
- b  input  WIDTH  data input, selected when s=2'b01.
- c  input  WIDTH  data input, selected when s=2'b10.
- d  input  WIDTH  data input, selected when s=2'b11.
- s  input  2  select.
- out  output  WIDTH  combinational selected data.
- out_q  output  WIDTH  registered selected data.
- out_par  output  1  even parity of out_q; present only with MUX4_TO_1_PARITY_EN.

Behaviour:
- Select encoding: out = a when s=00, b when s=01, c when s=10, d when s=11.
- Decode is full-case; there is no default/illegal select value.
- out is purely combinational:
  - Zero-cycle latency.
  - Independent of clk and rst.
  - Tracks any change on s or on the currently selected input within the same delta.
  - Unselected inputs have no effect on out, even when they are X/Z.
- out_q:
  - On a rising clk edge with rst low, out_q <= out.
  - One-cycle latency relative to out.
- Reset:
  - rst high forces out_q to all-zero immediately (asynchronous), regardless of clk.
  - out_q stays zero while rst is held high.
  - Release is synchronous in effect: the first rising clk edge after rst falls loads out.
  - Reset asserted mid-operation clears out_q at once.
  - out is unaffected by reset.
- Simultaneous events:
  - A change of s and of the selected data at the same instant gives out = the new selection of the new data.
  - out_q captures whatever out holds at the clock edge.
- Width rule: all data paths are exactly WIDTH bits; no extension or truncation.
- No handshake; out_q updates every cycle (no enable).

Optional Feature:
- Macro: MUX4_TO_1_PARITY_EN.
- Defined:
  - Adds output out_par = XOR-reduction of out_q, registered in the same always block as out_q.
  - out_par resets to 0 asynchronously with rst.
  - out_par is valid on the same cycle as out_q.
- Undefined: out_par port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux4_to_1_pkg holds:
  - Select constants SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11.
  - typedef sel_t (logic [1:0]).
  - Default width constant MUX4_TO_1_WIDTH_DEF=1.
- One sub-module is natural: mux4_to_1_core, the combinational WIDTH-bit selector with no clock.
- The top module instantiates mux4_to_1_core and adds the out_q register and the optional parity.

Test Plan:
- WIDTH=1: step s through 00, 01, 10, 11; at each step drive the selected input 0 then 1, holding each value 20 ns.
  - Required: out equals the driven value after each step.
  - Required: unselected inputs left X never propagate to out.
- WIDTH=8, a=8'h11, b=8'h22, c=8'h33, d=8'h44, s=2'b10.
  - Required: out=8'h33 immediately.
  - Required: out_q=8'h33 after one rising clk edge.
- Hold rst=1 and toggle clk with s=00, a=8'hFF.
  - Required: out_q=8'h00 throughout.
  - Required: out=8'hFF throughout.
  - Required: out_q=8'hFF on the first edge after rst falls.
- With out_q=8'h44, assert rst between clock edges.
  - Required: out_q drops to 8'h00 before the next edge.
- Change s from 00 to 11 and d from 8'h00 to 8'hA5 in the same timestep.
  - Required: out=8'hA5 in that timestep.
  - Required: out_q=8'hA5 at the next edge.
- With MUX4_TO_1_PARITY_EN and WIDTH=8, select 8'h07.
  - Required: out_par=1 one cycle later.
  - Required: select 8'h03 gives out_par=0 one cycle later.
  - Required: out_par=0 while rst is high.
